// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM type, defaults and counter width for the data-memory responder
package dmem_pkg;

  localparam int DMEM_WIDTH   = 32;
  localparam int DMEM_DEPTH   = 64;
  localparam int DMEM_LATENCY = 2;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter preload for the WAIT state; LATENCY==1 never enters WAIT so its value is irrelevant.
  function automatic logic [CNT_W-1:0] wait_preload(input int latency);
    return (latency > 1) ? CNT_W'(latency - 2) : '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x WIDTH word storage, synchronous write and combinational read
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-side load/store responder with fixed accept-to-response latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH   = DMEM_WIDTH,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int               IDX_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = wait_preload(LATENCY);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic             accept;
  logic             enter_resp;
  logic             mem_we;
  logic             acc_we;
  logic [WIDTH-1:0] acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic             acc_err;
  logic [WIDTH-1:0] mem_rdata;

  assign accept = req_valid && (state == IDLE);

  // With LATENCY==1 the access happens on the accepting edge, before the latches hold the request.
  assign acc_we    = (state == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;

  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   (acc_addr[WIDTH-1:2] >= (WIDTH-2)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready  = 1'b1;
        enter_resp = req_valid && (LATENCY == 1);
      end
      WAIT: begin
        enter_resp = (cnt == '0);
      end
      RESP: begin
        resp_valid = 1'b1;
      end
      default: ;
    endcase
    mem_we = enter_resp && acc_we && !acc_err && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= WAIT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Response fields are captured once and then held for the whole RESP stall.
      if (enter_resp) begin
        resp_rdata <= (!acc_we && !acc_err) ? mem_rdata : '0;
        resp_err   <= acc_err;
      end
    end
  end

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2, 4 and 1
module tb_dmem_responder;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: LATENCY 2, instance 1: LATENCY 4, instance 2: LATENCY 1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .WIDTH   (32),
      .DEPTH   (64),
      .LATENCY (g == 0 ? 2 : (g == 1 ? 4 : 1))
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input int u, input string tag);
    check({tag, "_req_ready"},  32'(req_ready[u]),  32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid[u]), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata[u],      32'd0);
    check({tag, "_resp_err"},   32'(resp_err[u]),   32'd0);
  endtask

  // One full transaction; request inputs are scrambled right after accept, and hold>0 stalls the response.
  task automatic do_req(input int u, input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    req_we[u]    = ~we;
    req_addr[u]  = addr ^ 32'h0000_00F0;
    req_wdata[u] = ~wdata;
    lat = 1;
    while (!resp_valid[u] && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat),            32'(exp_lat));
    check({tag, "_rdata"},   resp_rdata[u],       exp_rdata);
    check({tag, "_err"},     32'(resp_err[u]),    32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_valid[u] = 1'b1;
      req_we[u]    = 1'b1;
      req_addr[u]  = addr;
      req_wdata[u] = 32'h0BAD_0BAD;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_bp_valid"}, 32'(resp_valid[u]), 32'd1);
      check({tag, "_bp_rdata"}, resp_rdata[u],      exp_rdata);
      check({tag, "_bp_err"},   32'(resp_err[u]),   32'(exp_err));
      check({tag, "_bp_ready"}, 32'(req_ready[u]),  32'd0);
    end
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[u] = 1'b0;
    check({tag, "_resp_drop"}, 32'(resp_valid[u]), 32'd0);
    check({tag, "_back_idle"}, 32'(req_ready[u]),  32'd1);
  endtask

  initial begin
    int k;
    int n;
    int acc [8];

    for (int u = 0; u < 3; u++) begin
      rst[u]        = 1'b1;
      req_valid[u]  = 1'b0;
      req_we[u]     = 1'b0;
      req_addr[u]   = '0;
      req_wdata[u]  = '0;
      resp_ready[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check_reset_outputs(u, "por");
      rst[u] = 1'b0;
    end

    // LATENCY 2: store/load, misaligned, out of range, last word, backpressure
    do_req(0, "st8",    1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,          1'b0, 2, 0);
    do_req(0, "ld8",    1'b0, 32'h0000_0008, 32'h0,          32'hDEAD_BEEF, 1'b0, 2, 0);
    do_req(0, "st4",    1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,          1'b0, 2, 0);
    do_req(0, "st6mis", 1'b1, 32'h0000_0006, 32'h0000_1234, 32'h0,          1'b1, 2, 0);
    do_req(0, "ld4",    1'b0, 32'h0000_0004, 32'h0,          32'hCAFE_F00D, 1'b0, 2, 0);
    do_req(0, "ld100",  1'b0, 32'h0000_0100, 32'h0,          32'h0,          1'b1, 2, 0);
    do_req(0, "stfc",   1'b1, 32'h0000_00FC, 32'h600D_F00D, 32'h0,          1'b0, 2, 0);
    do_req(0, "ldfc",   1'b0, 32'h0000_00FC, 32'h0,          32'h600D_F00D, 1'b0, 2, 0);
    do_req(0, "ld8bp",  1'b0, 32'h0000_0008, 32'h0,          32'hDEAD_BEEF, 1'b0, 2, 5);
    do_req(0, "ld8re",  1'b0, 32'h0000_0008, 32'h0,          32'hDEAD_BEEF, 1'b0, 2, 0);

    // LATENCY 4: reset one edge after accept aborts the store
    do_req(1, "st10",   1'b1, 32'h0000_0010, 32'h1111_2222, 32'h0,          1'b0, 4, 0);
    do_req(1, "ld10",   1'b0, 32'h0000_0010, 32'h0,          32'h1111_2222, 1'b0, 4, 0);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h0000_0010;
    req_wdata[1] = 32'h55AA_55AA;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("mw_in_wait_valid", 32'(resp_valid[1]), 32'd0);
    check("mw_in_wait_ready", 32'(req_ready[1]),  32'd0);
    @(posedge clk);
    #1 rst[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_reset_outputs(1, "mw_rst");
    end
    rst[1] = 1'b0;
    do_req(1, "ld10aft", 1'b0, 32'h0000_0010, 32'h0,         32'h1111_2222, 1'b0, 4, 0);

    // LATENCY 1: eight back-to-back stores with resp_ready held high
    k = 0;
    n = 0;
    resp_ready[2] = 1'b1;
    @(negedge clk);
    while (n < 8 && k < 60) begin
      if (req_ready[2]) begin
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h0000_0020 + 32'(4 * n);
        req_wdata[2] = 32'hA5A5_0000 + 32'(n);
        acc[n]       = k + 1;
        n++;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      if (n > 0 && acc[n-1] == k) begin
        check("l1_resp_valid", 32'(resp_valid[2]), 32'd1);
        check("l1_resp_err",   32'(resp_err[2]),   32'd0);
      end
    end
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_ready[2] = 1'b0;
    check("l1_accepted", 32'(n), 32'd8);
    for (int i = 1; i < 8; i++) begin
      check("l1_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
    end
    do_req(2, "l1ld20", 1'b0, 32'h0000_0020, 32'h0, 32'hA5A5_0000, 1'b0, 1, 0);
    do_req(2, "l1ld3c", 1'b0, 32'h0000_003C, 32'h0, 32'hA5A5_0007, 1'b0, 1, 0);
    do_req(2, "l1bp",   1'b0, 32'h0000_0024, 32'h0, 32'hA5A5_0001, 1'b0, 1, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
